// File: rtl/rns_forward_scheduler.sv
// Binary-to-RNS forward converter: one restoring-division reduction stage is
// time-shared across NUM_MOD moduli, one shift position per cycle.
module rns_forward_scheduler #(
  parameter int NUM_MOD = 3,
  parameter int DW      = 12,
  parameter int MW      = 8,
  parameter int SHIFTS  = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [1:0]             cfg_idx,
  input  logic [MW-1:0]          cfg_moduli,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW-1:0]          in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_MOD*MW-1:0]  out_residue,
  output logic [NUM_MOD-1:0]     out_error
);

  localparam int CW = DW + MW;
  localparam int SW = $clog2(SHIFTS);
  localparam int KW = $clog2(NUM_MOD);
  localparam logic [SW-1:0] SH_TOP = SW'(SHIFTS - 1);
  localparam logic [KW-1:0] CH_TOP = KW'(NUM_MOD - 1);

  typedef enum logic [1:0] {S_IDLE, S_REDUCE, S_DONE} state_t;

  state_t                     r_state, w_state_nxt;
  logic [NUM_MOD-1:0][MW-1:0] r_mod;
  logic [NUM_MOD-1:0][MW-1:0] r_snap;
  logic [NUM_MOD-1:0][MW-1:0] r_res;
  logic [NUM_MOD-1:0]         r_err;
  logic [DW-1:0]              r_op;
  logic [DW-1:0]              r_rem;
  logic [KW-1:0]              r_ch;
  logic [SW-1:0]              r_sh;

  logic                       w_accept;
  logic                       w_last_sh;
  logic                       w_last_ch;
  logic [MW-1:0]              w_cur_mod;
  logic                       w_mod_zero;
  logic [CW-1:0]              w_cand;
  logic                       w_ge;
  logic [DW-1:0]              w_rem_nxt;

  // Held low during reset even though the state register may still read IDLE.
  assign in_ready    = (r_state == S_IDLE) && !rst;
  assign out_valid   = (r_state == S_DONE);
  assign out_residue = r_res;
  assign out_error   = r_err;

  assign w_accept  = in_valid && in_ready;
  assign w_last_sh = (r_sh == '0);
  assign w_last_ch = (r_ch == CH_TOP);

  // Candidate is widened before shifting so modulus << 11 never truncates.
  assign w_cur_mod  = r_snap[r_ch];
  assign w_mod_zero = (w_cur_mod == '0);
  assign w_cand     = CW'(w_cur_mod) << r_sh;
  assign w_ge       = (CW'(r_rem) >= w_cand);
  assign w_rem_nxt  = w_ge ? DW'(CW'(r_rem) - w_cand) : r_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_MOD; k++) r_mod[k] <= MW'(255 - k);
    end else if (cfg_we) begin
      for (int k = 0; k < NUM_MOD; k++)
        if (cfg_idx == 2'(k)) r_mod[k] <= cfg_moduli;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_REDUCE;
      S_REDUCE: if (w_last_sh && w_last_ch) w_state_nxt = S_DONE;
      S_DONE:   if (out_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap <= '0;
      r_res  <= '0;
      r_err  <= '0;
      r_op   <= '0;
      r_rem  <= '0;
      r_ch   <= '0;
      r_sh   <= SH_TOP;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op   <= in_data;
            r_rem  <= in_data;
            r_ch   <= '0;
            r_sh   <= SH_TOP;
            r_snap <= r_mod;
          end
        end
        S_REDUCE: begin
          if (w_last_sh) begin
            // A zero modulus leaves rem at the operand; report 0 and flag it.
            r_res[r_ch] <= w_mod_zero ? '0 : w_rem_nxt[MW-1:0];
            r_err[r_ch] <= w_mod_zero;
            r_rem       <= r_op;
            if (!w_last_ch) begin
              r_ch <= r_ch + 1'b1;
              r_sh <= SH_TOP;
            end
          end else begin
            r_rem <= w_rem_nxt;
            r_sh  <= r_sh - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rns_forward_scheduler.sv
// Directed and randomized checks of rns_forward_scheduler against a modulo-arithmetic model.
module tb_rns_forward_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [7:0]  cfg_moduli = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] out_residue;
  logic [2:0]  out_error;

  rns_forward_scheduler dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_moduli(cfg_moduli),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_residue(out_residue), .out_error(out_error)
  );

  always #5 clk = ~clk;

  int ncheck = 0;
  int npass  = 0;
  int unsigned mdl_mod [3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncheck++;
    assert (got === exp) npass++;
    else $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_mod(input int idx, input int val);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_moduli = 8'(val);
    step;
    cfg_we = 1'b0;
    if (idx < 3) mdl_mod[idx] = val;
  endtask

  // cfg_at: cycle offset from accept for a config write (0 = accept cycle, <0 = none)
  task automatic convert(input int x, input int hold, input int cfg_at, input int cfg_i, input int cfg_v);
    int unsigned snap [3];
    logic [23:0] er;
    logic [2:0]  ee;
    int lat;
    snap = mdl_mod;
    er = '0; ee = '0;
    for (int k = 0; k < 3; k++) begin
      er[8*k +: 8] = (snap[k] == 0) ? 8'd0 : 8'(x % snap[k]);
      ee[k] = (snap[k] == 0);
    end
    chk("idle_ready", in_ready, 1);
    in_valid = 1'b1; in_data = 12'(x);
    if (cfg_at == 0) begin cfg_we = 1'b1; cfg_idx = 2'(cfg_i); cfg_moduli = 8'(cfg_v); end
    step;
    in_valid = 1'b0; cfg_we = 1'b0;
    if (cfg_at == 0 && cfg_i < 3) mdl_mod[cfg_i] = cfg_v;
    lat = 1;
    while (!out_valid && lat < 60) begin
      chk("busy_ready", in_ready, 0);
      in_valid = 1'($urandom); in_data = 12'($urandom);
      if (lat == cfg_at) begin cfg_we = 1'b1; cfg_idx = 2'(cfg_i); cfg_moduli = 8'(cfg_v); end
      step;
      if (lat == cfg_at) begin
        cfg_we = 1'b0;
        if (cfg_i < 3) mdl_mod[cfg_i] = cfg_v;
      end
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", lat, 37);
    chk("residue", out_residue, er);
    chk("error", out_error, ee);
    chk("done_ready", in_ready, 0);
    repeat (hold) begin
      step;
      chk("hold_valid", out_valid, 1);
      chk("hold_residue", out_residue, er);
      chk("hold_error", out_error, ee);
      chk("hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    chk("post_valid", out_valid, 0);
    chk("post_ready", in_ready, 1);
  endtask

  initial begin
    int m;
    int seen;
    // Reset state
    rst = 1'b1;
    step; step;
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_residue", out_residue, 0);
    chk("rst_error", out_error, 0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", in_ready, 1);
    mdl_mod[0] = 255; mdl_mod[1] = 254; mdl_mod[2] = 253;

    // Defaults
    convert(4095, 0, -1, 0, 0);

    // Small moduli including 1
    set_mod(0, 7); set_mod(1, 1); set_mod(2, 16);
    convert(100, 0, -1, 0, 0);
    convert(0, 0, -1, 0, 0);

    // Zero modulus on ch1; index 3 write is ignored
    set_mod(0, 255); set_mod(1, 0); set_mod(2, 253);
    set_mod(3, 9);
    convert(1234, 0, -1, 0, 0);
    set_mod(1, 254);

    // Backpressure then back-to-back
    convert(4095, 5, -1, 0, 0);
    convert(256, 0, -1, 0, 0);

    // Config writes during REDUCE and in the accept cycle take effect next accept
    convert(4095, 0, 10, 0, 10);
    convert(4095, 0, 0, 0, 7);
    convert(4095, 0, -1, 0, 0);
    set_mod(0, 255);

    // Randomized operands and moduli
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 9))
            0:       m = 0;
            1:       m = 1;
            default: m = int'($urandom_range(2, 255));
          endcase
          set_mod(k, m);
        end
      end
      convert(int'($urandom_range(0, 4095)), int'($urandom_range(0, 3)), -1, 0, 0);
    end

    // Reset in the middle of a conversion
    set_mod(0, 11); set_mod(1, 12); set_mod(2, 13);
    in_valid = 1'b1; in_data = 12'd3000;
    step;
    in_valid = 1'b0;
    repeat (19) step;
    rst = 1'b1;
    #1;
    chk("midrst_ready", in_ready, 0);
    step;
    rst = 1'b0;
    #1;
    mdl_mod[0] = 255; mdl_mod[1] = 254; mdl_mod[2] = 253;
    chk("midrst_after_ready", in_ready, 1);
    chk("midrst_after_valid", out_valid, 0);
    seen = 0;
    repeat (45) begin
      step;
      if (out_valid) seen++;
    end
    chk("midrst_no_output", seen, 0);
    convert(4095, 0, -1, 0, 0);

    $display("%0d/%0d checks passed", npass, ncheck);
    $finish;
  end

endmodule
